slow_line_memory: RTL and testbench

- Behavioural-plus-synthesizable model of the slow off-chip memory behind each cache (instruction and data).
- Serves whole 128-bit cache lines addressed by line index (byte address bits [31:4]).
- Fixed multi-cycle latency and a single-cycle ready handshake.
- Two instances sit beside CHIP: one for the I-cache, one for the D-cache.

---
 rtl/slow_line_memory.sv | 118 +++++++++++
 tb/tb_slow_line_memory.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/slow_line_memory.sv
`default_nettype none
// ============================================================================
// Module   : slow_line_memory
// Purpose  : Fixed-latency 128-bit line memory standing in for off-chip DRAM
//            behind a cache; one transaction per LATENCY+1 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module slow_line_memory #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 256,
    parameter int AW      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_cnt_load = 8'(LATENCY - 1);

    logic [127:0] mem [0:DEPTH-1];

    state_t          r_state;
    state_t          w_state_next;
    logic [7:0]      r_cnt;
    logic [7:0]      w_cnt_next;
    logic            r_is_write;
    logic            w_is_write_next;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   w_idx_next;
    logic [127:0]    r_wdata;
    logic [127:0]    w_wdata_next;
    logic            w_enter_done;
    logic            w_enter_read;
    logic            w_unused_addr;

    // Upper line-address bits alias onto the array and are deliberately dropped.
    assign w_unused_addr = ^mem_addr[27:AW];

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_is_write_next = r_is_write;
        w_idx_next      = r_idx;
        w_wdata_next    = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    w_is_write_next = mem_write;
                    w_idx_next      = mem_addr[AW-1:0];
                    w_wdata_next    = mem_wdata;
                    w_cnt_next      = c_cnt_load;
                    w_state_next    = (LATENCY == 1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                // Leaving on the edge where the count reaches zero places DONE
                // exactly LATENCY cycles after acceptance.
                if (r_cnt <= 8'd1) begin
                    w_cnt_next   = 8'd0;
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next   = r_cnt - 8'd1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_enter_done = (w_state_next == S_DONE) && (r_state != S_DONE);
    assign w_enter_read = w_enter_done && !w_is_write_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_is_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            mem_ready  <= 1'b0;
            mem_rdata  <= 128'h0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_is_write <= w_is_write_next;
            r_idx      <= w_idx_next;
            r_wdata    <= w_wdata_next;
            mem_ready  <= w_enter_done;
            if (w_enter_read) begin
                mem_rdata <= mem[w_idx_next];
            end
        end
    end

    // Array has no reset so it can be preloaded; a reset during DONE aborts the write.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_DONE) && r_is_write) begin
            mem[r_idx] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slow_line_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_slow_line_memory
// Purpose  : Directed self-checking bench for slow_line_memory (LATENCY 10 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_slow_line_memory;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_read = 1'b0, mem_write = 1'b0;
    logic [27:0]  mem_addr = '0;
    logic [127:0] mem_wdata = '0;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         r1_read = 1'b0, r1_write = 1'b0;
    logic [27:0]  r1_addr = '0;
    logic [127:0] r1_wdata = '0;
    logic [127:0] r1_rdata;
    logic         r1_ready;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] P5 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] P9 = 128'h09090909090909090909090909090909;
    localparam logic [127:0] P3 = 128'h33333333333333333333333333333333;
    localparam logic [127:0] P4 = 128'h44440000444400004444000044440000;
    localparam logic [127:0] A5 = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;

    always #5 clk = ~clk;

    slow_line_memory #(.LATENCY(10), .DEPTH(256), .AW(8)) u_dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    slow_line_memory #(.LATENCY(1), .DEPTH(256), .AW(8)) u_dut1 (
        .clk(clk), .rst(rst), .mem_read(r1_read), .mem_write(r1_write),
        .mem_addr(r1_addr), .mem_wdata(r1_wdata),
        .mem_rdata(r1_rdata), .mem_ready(r1_ready)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns latency in cycles (0 = timeout), data at the
    // ready strobe, and mem_ready one cycle later.
    task automatic txn(input bit sel1, input logic rd, input logic wr,
                       input logic [27:0] addr, input logic [127:0] wd,
                       output int lat, output logic [127:0] rdat, output logic after);
        if (sel1) begin
            r1_read = rd; r1_write = wr; r1_addr = addr; r1_wdata = wd;
        end else begin
            mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wd;
        end
        lat  = 0;
        rdat = 'x;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if ((sel1 ? r1_ready : mem_ready) === 1'b1) begin
                lat  = n;
                rdat = sel1 ? r1_rdata : mem_rdata;
                break;
            end
        end
        r1_read = 1'b0; r1_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        after = sel1 ? r1_ready : mem_ready;
    endtask

    initial begin
        int           lat;
        int           pulses;
        logic [127:0] rdat;
        logic         after;

        u_dut.mem[5]  = P5;
        u_dut.mem[9]  = P9;
        u_dut.mem[3]  = P3;
        u_dut1.mem[4] = P4;

        repeat (2) @(negedge clk);
        check("reset_ready", 128'(mem_ready), 128'd0);
        check("reset_rdata", mem_rdata, 128'h0);
        rst = 1'b0;

        // Read a preloaded line.
        txn(1'b0, 1'b1, 1'b0, 28'h5, '0, lat, rdat, after);
        check("rd5_latency", 128'(lat), 128'd10);
        check("rd5_data", rdat, P5);
        check("rd5_single_pulse", 128'(after), 128'd0);

        // Write must leave mem_rdata untouched.
        txn(1'b0, 1'b0, 1'b1, 28'h7, A5, lat, rdat, after);
        check("wr7_latency", 128'(lat), 128'd10);
        check("wr7_rdata_hold", rdat, P5);
        check("wr7_single_pulse", 128'(after), 128'd0);
        check("wr7_rdata_hold_after", mem_rdata, P5);

        txn(1'b0, 1'b1, 1'b0, 28'h7, '0, lat, rdat, after);
        check("rd7_latency", 128'(lat), 128'd10);
        check("rd7_data", rdat, A5);

        // 0x105 aliases onto line 5.
        txn(1'b0, 1'b0, 1'b1, 28'h105, 128'h1, lat, rdat, after);
        check("wr105_latency", 128'(lat), 128'd10);
        txn(1'b0, 1'b1, 1'b0, 28'h5, '0, lat, rdat, after);
        check("alias_rd5_data", rdat, 128'h1);

        // Requester drops its read one cycle late; no second transaction.
        mem_read = 1'b1; mem_addr = 28'h7;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                lat  = n;
                rdat = mem_rdata;
                break;
            end
        end
        @(posedge clk);
        #1 mem_read = 1'b0;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) pulses++;
        end
        check("late_drop_latency", 128'(lat), 128'd10);
        check("late_drop_data", rdat, A5);
        check("late_drop_no_extra", 128'(pulses), 128'd0);

        // Reset mid-write (counter at 4) must abort the write.
        mem_write = 1'b1; mem_addr = 28'h9; mem_wdata = 128'hBEEF;
        repeat (6) @(negedge clk);
        check("midwr_no_ready", 128'(mem_ready), 128'd0);
        rst = 1'b1; mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("post_reset_ready", 128'(mem_ready), 128'd0);
        check("post_reset_rdata", mem_rdata, 128'h0);
        txn(1'b0, 1'b1, 1'b0, 28'h9, '0, lat, rdat, after);
        check("rd9_latency", 128'(lat), 128'd10);
        check("rd9_old_data", rdat, P9);

        // Read and write together: write wins.
        txn(1'b0, 1'b1, 1'b1, 28'h3, 128'h2, lat, rdat, after);
        check("rw3_latency", 128'(lat), 128'd10);
        check("rw3_rdata_hold", rdat, P9);
        txn(1'b0, 1'b1, 1'b0, 28'h3, '0, lat, rdat, after);
        check("rd3_data", rdat, 128'h2);

        // LATENCY=1 instance.
        txn(1'b1, 1'b1, 1'b0, 28'h4, '0, lat, rdat, after);
        check("l1_rd4_latency", 128'(lat), 128'd1);
        check("l1_rd4_data", rdat, P4);
        check("l1_rd4_single_pulse", 128'(after), 128'd0);
        txn(1'b1, 1'b0, 1'b1, 28'h4, 128'h44, lat, rdat, after);
        check("l1_wr4_latency", 128'(lat), 128'd1);
        txn(1'b1, 1'b1, 1'b0, 28'h4, '0, lat, rdat, after);
        check("l1_rd4_new_data", rdat, 128'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
